add_one_axil_regs: RTL

// AXI4-Lite slave register stage downstream of the system AXI master: four R/W operand

---
 rtl/add_one_axil_regs.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/add_one_axil_regs.sv
// rtl/add_one_axil_regs.sv - AXI4-Lite slave with four operand registers and four operand+1 result registers
// One outstanding read and one outstanding write; the upper half of the map is read-only.
module add_one_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY
);

   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int NB = DW / 8;

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_COMMIT, W_RESP} wstate_t;

   wstate_t           wstate_q;
   logic              awready_q, wready_q, bvalid_q;
   logic [1:0]        bresp_q;
   logic [2:0]        waddr_q;
   logic [DW-1:0]     wdata_q;
   logic [NB-1:0]     wstrb_q;
   logic [3:0][DW-1:0] operand_q, operand_d;

   logic              arready_q, rvalid_q;
   logic [DW-1:0]     rdata_q;
   logic [DW-1:0]     rd_val;

   logic aw_hs, w_hs;
   assign aw_hs = S_AXI_AWVALID && awready_q;
   assign w_hs  = S_AXI_WVALID && wready_q;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // A channel whose READY is already low has been captured; the FSM only waits on the other.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               if (aw_hs) begin
                  waddr_q   <= S_AXI_AWADDR[4:2];
                  awready_q <= 1'b0;
               end else begin
                  awready_q <= 1'b1;
               end
               if (w_hs) begin
                  wdata_q  <= S_AXI_WDATA;
                  wstrb_q  <= S_AXI_WSTRB;
                  wready_q <= 1'b0;
               end else begin
                  wready_q <= 1'b1;
               end
               if (aw_hs && w_hs)
                  wstate_q <= W_COMMIT;
               else if (aw_hs || w_hs)
                  wstate_q <= W_WAIT;
            end
            W_WAIT: begin
               if (aw_hs) begin
                  waddr_q   <= S_AXI_AWADDR[4:2];
                  awready_q <= 1'b0;
                  wstate_q  <= W_COMMIT;
               end
               if (w_hs) begin
                  wdata_q  <= S_AXI_WDATA;
                  wstrb_q  <= S_AXI_WSTRB;
                  wready_q <= 1'b0;
                  wstate_q <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               bvalid_q <= 1'b1;
               bresp_q  <= waddr_q[2] ? 2'b10 : 2'b00;
               wstate_q <= W_RESP;
            end
            default: begin
               if (S_AXI_BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      operand_d = operand_q;
      if (wstate_q == W_COMMIT && !waddr_q[2]) begin
         for (int i = 0; i < NB; i++) begin
            if (wstrb_q[i])
               operand_d[waddr_q[1:0]][8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         operand_q <= '0;
      else
         operand_q <= operand_d;
   end

   // Reads sample operand_q, so a write committing on the same edge is not yet visible.
   assign rd_val = S_AXI_ARADDR[4] ? operand_q[S_AXI_ARADDR[3:2]] + DW'(1)
                                   : operand_q[S_AXI_ARADDR[3:2]];

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else if (S_AXI_ARVALID && arready_q) begin
         rdata_q   <= rd_val;
         rvalid_q  <= 1'b1;
         arready_q <= 1'b0;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_q  <= 1'b0;
         arready_q <= 1'b1;
      end else begin
         arready_q <= !rvalid_q;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = 2'b00;

endmodule
